alu_seq_ctrl: RTL
=================

// Module: alu_seq_ctrl
// PURPOSE
//   Parametrised, multi-cycle ALU controller driven over a narrow BUS_WIDTH byte bus with command strobes.
//   Operands of DATA_WIDTH bits are loaded in chunks. Execution runs chunk-serially, LSB first, with carry chained.
//   Result and status are read back chunk by chunk. Sits between the top-level pin bus and the arithmetic datapath.
// PARAMETERS
//   DATA_WIDTH  32  operand/result width; must be a multiple of BUS_WIDTH
//   BUS_WIDTH    8  width of bus_in/bus_out and of one ALU slice; NCHUNK = DATA_WIDTH/BUS_WIDTH (>=1)
// PORTS
//   clk      in   1          clock; all state updates on posedge
//   rst_n    in   1          reset, synchronous, active-low
//   bus_in   in   BUS_WIDTH  operand chunk for WR_A/WR_B
//   ctrl_in  in   8          [7:5] cmd, [4:0] arg
//   strobe   in   1          command valid; sampled on posedge
//   bus_out  out  BUS_WIDTH  registered read data (result chunk or status)
//   busy     out  1          high while state != IDLE
//   done     out  1          one-cycle pulse in DONE state
// BEHAVIOUR
//   Reset (rst_n=0 at posedge):
//     A, B, result, flags, op, rd_ptr, err, bus_out, busy and done all become 0; state becomes IDLE.
//     A reset in mid-EXEC aborts the operation with no partial commit.
//   Command acceptance: a command is accepted when strobe=1 and busy=0.
//     strobe=1 with busy=1 is ignored and sets the sticky err flag.
//   Commands (cmd):
//     000 NOP.
//     001 WR_A: A <= {bus_in, A[DW-1:BW]}; after NCHUNK writes, the first chunk written is the LSB chunk.
//     010 WR_B: same as WR_A, applied to B.
//     011 SET_OP: op <= arg[3:0]; cin <= arg[4].
//     100 EXEC: start execution; rd_ptr <= 0.
//     101 RD_RES: bus_out <= result chunk[rd_ptr]; rd_ptr++; rd_ptr wraps from NCHUNK-1 to 0.
//     110 ACC_EXEC: see CONFIGURATION.
//     111 RD_STATUS: bus_out <= {err, 3'b0, V, N, Z, C}, zero-extended to BUS_WIDTH; err is cleared in the same cycle.
//   bus_out latency: 1 cycle after the accepting edge; bus_out holds its value otherwise.
//   FSM: IDLE -> EXEC on accepted EXEC.
//     EXEC lasts exactly NCHUNK cycles. Chunk k is processed in cycle k, with the slice carry registered into chunk k+1.
//     EXEC -> DONE, then DONE -> IDLE after 1 cycle.
//     busy is high for NCHUNK+1 cycles. result and flags update at the DONE edge; done=1 in DONE.
//   Ops (op):
//     0 ADD A+B+cin.
//     1 SUB A-B-cin, with cin as borrow-in.
//     2 AND.  3 OR.  4 XOR.
//     5 NOT A.
//     6 PASS B.
//     7 SHL: {A[DW-2:0], cin}.
//     8-15 reserved: result 0, C=V=0.
//   Flags:
//     C = carry-out of the final chunk for ADD/SHL (A[DW-1] for SHL), borrow-out for SUB, 0 otherwise.
//     Z = all result bits 0.
//     N = result[DW-1].
//     V = signed overflow for ADD/SUB only, 0 otherwise.
//   Arithmetic is modulo 2^DATA_WIDTH. No carry leaks between EXECs: the chunk-0 carry is always cin.
//   Writes to A/B while IDLE never disturb result or flags.
//   NCHUNK=1: rd_ptr is a constant 0 and EXEC takes 1 cycle.
// CONFIGURATION
//   ALU_CTRL_ACC_EN defined:
//     cmd 110 ACC_EXEC behaves as EXEC and additionally copies the result into A at the DONE edge.
//   ALU_CTRL_ACC_EN undefined:
//     cmd 110 is a NOP and does not set err.
// STRUCTURE
//   Shared constants header alu_ctrl_pkg.vh holds:
//     cmd codes; op codes; FSM state encodings (IDLE/EXEC/DONE); status bit positions (C=0, Z=1, N=2, V=3, ERR=7).
//   Sub-module alu_slice: combinational, BUS_WIDTH wide.
//     Inputs: a, b, op, cin. Outputs: y, cout, vout (signed overflow of the slice MSB).
//     Reused every EXEC cycle. The controller holds chunk counter, carry register and zero accumulator.
// TESTING (DATA_WIDTH=16, BUS_WIDTH=8 unless noted)
//   ADD carry chain:
//     WR_A 0xFF, 0x00; WR_B 0x01, 0x00; SET_OP ADD cin=0; EXEC.
//     Expect: busy for 3 cycles, then done. RD_RES gives 0x00 then 0x01. RD_STATUS = 0x00.
//   SUB borrow:
//     A=0x0000, B=0x0001, SUB cin=0.
//     Expect: result 0xFFFF. RD_STATUS = 0x05 (N=1, C=1). A third RD_RES wraps and returns 0xFF (LSB chunk).
//   Busy collision:
//     Issue WR_A strobe during EXEC.
//     Expect: A unchanged. First RD_STATUS has bit7=1; second RD_STATUS has bit7=0.
//   SHL across chunks:
//     A=0x0080, SHL cin=1.
//     Expect: result 0x0101, C=0. Then A=0x8000, SHL cin=0: result 0x0000, Z=1, C=1.
//   ACC mode (ALU_CTRL_ACC_EN):
//     A=1, B=1, ADD; ACC_EXEC twice.
//     Expect: result 3. Without the macro, cmd 110 leaves result and err unchanged.
//   Reset mid-EXEC:
//     With DATA_WIDTH=32, drop rst_n in the 2nd EXEC cycle.
//     Expect: next cycle busy=0, done=0, bus_out=0. RD_RES returns 0x00. No done pulse.

Source files
------------

// File: rtl/alu_seq_ctrl_pkg.sv
// ============================================================================
// Module  : alu_seq_ctrl_pkg
// Purpose : Shared constants for the chunk-serial ALU controller: command
//           codes, ALU op codes, FSM state encoding and status-byte bit
//           positions.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_seq_ctrl_pkg;

  // Command codes carried in ctrl_in[7:5]
  localparam logic [2:0] CMD_NOP       = 3'd0;
  localparam logic [2:0] CMD_WR_A      = 3'd1;
  localparam logic [2:0] CMD_WR_B      = 3'd2;
  localparam logic [2:0] CMD_SET_OP    = 3'd3;
  localparam logic [2:0] CMD_EXEC      = 3'd4;
  localparam logic [2:0] CMD_RD_RES    = 3'd5;
  localparam logic [2:0] CMD_ACC_EXEC  = 3'd6;
  localparam logic [2:0] CMD_RD_STATUS = 3'd7;

  // ALU op codes; 8..15 are reserved and produce a zero result
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_PASS = 4'd6;
  localparam logic [3:0] OP_SHL  = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit positions inside the status byte (and the low four in the flag reg)
  localparam int STAT_C   = 0;
  localparam int STAT_Z   = 1;
  localparam int STAT_N   = 2;
  localparam int STAT_V   = 3;
  localparam int STAT_ERR = 7;

endpackage

`default_nettype wire

// File: rtl/alu_seq_ctrl_slice.sv
// ============================================================================
// Module  : alu_seq_ctrl_slice
// Purpose : Combinational W-bit ALU slice, reused once per chunk while the
//           controller walks an operand LSB chunk first.
// Ports   : i_a, i_b  slice operands
//           i_op      ALU op code
//           i_cin     carry-in (ADD/SHL) or borrow-in (SUB)
//           o_y       slice result
//           o_cout    carry-out (ADD/SHL) or borrow-out (SUB), else 0
//           o_vout    signed overflow at the slice MSB (ADD/SUB only)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_seq_ctrl_slice
  import alu_seq_ctrl_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [3:0]   i_op,
  input  logic         i_cin,
  output logic [W-1:0] o_y,
  output logic         o_cout,
  output logic         o_vout
);

  logic [W:0] w_sum;
  logic [W:0] w_dif;
  logic [W:0] w_shl;

  // Subtraction as a + ~b + ~borrow_in; the borrow-out is the inverted carry.
  assign w_sum = {1'b0, i_a} + {1'b0, i_b}  + {{W{1'b0}}, i_cin};
  assign w_dif = {1'b0, i_a} + {1'b0, ~i_b} + {{W{1'b0}}, ~i_cin};
  // Shift left: the carry-in fills the LSB and the MSB leaves as carry-out.
  assign w_shl = {i_a, i_cin};

  always_comb begin
    o_y    = '0;
    o_cout = 1'b0;
    o_vout = 1'b0;
    case (i_op)
      OP_ADD: begin
        o_y    = w_sum[W-1:0];
        o_cout = w_sum[W];
        o_vout = (i_a[W-1] == i_b[W-1]) && (w_sum[W-1] != i_a[W-1]);
      end
      OP_SUB: begin
        o_y    = w_dif[W-1:0];
        o_cout = ~w_dif[W];
        o_vout = (i_a[W-1] != i_b[W-1]) && (w_dif[W-1] != i_a[W-1]);
      end
      OP_AND:  o_y = i_a & i_b;
      OP_OR:   o_y = i_a | i_b;
      OP_XOR:  o_y = i_a ^ i_b;
      OP_NOT:  o_y = ~i_a;
      OP_PASS: o_y = i_b;
      OP_SHL: begin
        o_y    = w_shl[W-1:0];
        o_cout = w_shl[W];
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_seq_ctrl.sv
// ============================================================================
// Module  : alu_seq_ctrl
// Purpose : Multi-cycle ALU controller on a narrow command bus. Operands are
//           loaded a chunk at a time, executed chunk-serially (LSB first,
//           carry chained through a register) and read back chunk by chunk.
// Ports   : clk      clock, rising edge
//           rst_n    synchronous active-low reset
//           bus_in   operand chunk for WR_A / WR_B
//           ctrl_in  [7:5] command, [4:0] argument
//           strobe   command valid
//           bus_out  registered read data (result chunk or status byte)
//           busy     high while the FSM is not IDLE
//           done     one-cycle pulse in the DONE state
// Config  : ALU_CTRL_ACC_EN  when defined, command 110 runs EXEC and also
//                            writes the result back into A; otherwise it is
//                            a NOP.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_seq_ctrl
  import alu_seq_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BUS_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BUS_WIDTH-1:0] bus_in,
  input  logic [7:0]           ctrl_in,
  input  logic                 strobe,
  output logic [BUS_WIDTH-1:0] bus_out,
  output logic                 busy,
  output logic                 done
);

  localparam int NCHUNK = DATA_WIDTH / BUS_WIDTH;
  localparam int PW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [PW-1:0] LAST = PW'(NCHUNK - 1);

  state_t r_state;
  state_t w_state_nxt;

  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [DATA_WIDTH-1:0] r_res;
  logic [DATA_WIDTH-1:0] r_wres;    // result being assembled during EXEC
  logic [3:0]            r_flags;   // indexed by STAT_C/Z/N/V
  logic [3:0]            r_op;
  logic                  r_cin;
  logic [PW-1:0]         r_rd_ptr;
  logic [PW-1:0]         r_cnt;
  logic                  r_carry;
  logic                  r_zacc;
  logic                  r_acc;
  logic                  r_err;
  logic [BUS_WIDTH-1:0]  r_bus_out;

  logic [2:0]            w_cmd;
  logic [4:0]            w_arg;
  logic                  w_busy;
  logic                  w_accept;
  logic                  w_acc_start;
  logic                  w_start;
  logic                  w_last;
  logic [BUS_WIDTH-1:0]  w_y;
  logic                  w_cout;
  logic                  w_vout;
  logic [DATA_WIDTH+BUS_WIDTH-1:0] w_a_ins;
  logic [DATA_WIDTH+BUS_WIDTH-1:0] w_b_ins;
  logic [DATA_WIDTH+BUS_WIDTH-1:0] w_res_ins;
  logic [7:0]            w_stat8;
  logic [BUS_WIDTH-1:0]  w_status;

  assign w_cmd    = ctrl_in[7:5];
  assign w_arg    = ctrl_in[4:0];
  assign w_busy   = (r_state != ST_IDLE);
  assign w_accept = strobe && !w_busy;
  assign w_last   = (r_cnt == LAST);

`ifdef ALU_CTRL_ACC_EN
  assign w_acc_start = w_accept && (w_cmd == CMD_ACC_EXEC);
`else
  assign w_acc_start = 1'b0;
`endif

  assign w_start = (w_accept && (w_cmd == CMD_EXEC)) || w_acc_start;

  // Chunk shift-ins: the new chunk enters at the top, so after NCHUNK
  // insertions the first one sits in the LSB position. Written as a wide
  // concatenation so it stays legal when NCHUNK == 1.
  assign w_a_ins   = {bus_in, r_a};
  assign w_b_ins   = {bus_in, r_b};
  assign w_res_ins = {w_y, r_wres};

  alu_seq_ctrl_slice #(
    .W (BUS_WIDTH)
  ) u_slice (
    .i_a    (r_a[r_cnt*BUS_WIDTH +: BUS_WIDTH]),
    .i_b    (r_b[r_cnt*BUS_WIDTH +: BUS_WIDTH]),
    .i_op   (r_op),
    .i_cin  (r_carry),
    .o_y    (w_y),
    .o_cout (w_cout),
    .o_vout (w_vout)
  );

  always_comb begin
    w_stat8           = '0;
    w_stat8[STAT_C]   = r_flags[STAT_C];
    w_stat8[STAT_Z]   = r_flags[STAT_Z];
    w_stat8[STAT_N]   = r_flags[STAT_N];
    w_stat8[STAT_V]   = r_flags[STAT_V];
    w_stat8[STAT_ERR] = r_err;
    w_status          = '0;
    for (int i = 0; i < BUS_WIDTH && i < 8; i++) begin
      w_status[i] = w_stat8[i];
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start) w_state_nxt = ST_EXEC;
      ST_EXEC: if (w_last)  w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_res     <= '0;
      r_wres    <= '0;
      r_flags   <= '0;
      r_op      <= '0;
      r_cin     <= 1'b0;
      r_rd_ptr  <= '0;
      r_cnt     <= '0;
      r_carry   <= 1'b0;
      r_zacc    <= 1'b0;
      r_acc     <= 1'b0;
      r_err     <= 1'b0;
      r_bus_out <= '0;
    end else begin
      if (strobe && w_busy) r_err <= 1'b1;

      if (w_accept) begin
        case (w_cmd)
          CMD_WR_A:   r_a <= w_a_ins[DATA_WIDTH+BUS_WIDTH-1:BUS_WIDTH];
          CMD_WR_B:   r_b <= w_b_ins[DATA_WIDTH+BUS_WIDTH-1:BUS_WIDTH];
          CMD_SET_OP: begin
            r_op  <= w_arg[3:0];
            r_cin <= w_arg[4];
          end
          CMD_RD_RES: begin
            r_bus_out <= r_res[r_rd_ptr*BUS_WIDTH +: BUS_WIDTH];
            r_rd_ptr  <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + 1'b1;
          end
          CMD_RD_STATUS: begin
            r_bus_out <= w_status;
            r_err     <= 1'b0;
          end
          default: ;
        endcase
      end

      // Chunk 0 always starts from cin, so nothing carries over between runs.
      if (w_start) begin
        r_rd_ptr <= '0;
        r_cnt    <= '0;
        r_carry  <= r_cin;
        r_zacc   <= 1'b1;
        r_acc    <= w_acc_start;
      end

      if (r_state == ST_EXEC) begin
        r_wres  <= w_res_ins[DATA_WIDTH+BUS_WIDTH-1:BUS_WIDTH];
        r_carry <= w_cout;
        r_zacc  <= r_zacc & ~|w_y;
        r_cnt   <= r_cnt + 1'b1;
        // Commit only on the final chunk so an aborted run leaves no trace.
        if (w_last) begin
          r_res            <= w_res_ins[DATA_WIDTH+BUS_WIDTH-1:BUS_WIDTH];
          r_flags[STAT_C]  <= w_cout;
          r_flags[STAT_Z]  <= r_zacc & ~|w_y;
          r_flags[STAT_N]  <= w_y[BUS_WIDTH-1];
          r_flags[STAT_V]  <= w_vout;
          if (r_acc) r_a   <= w_res_ins[DATA_WIDTH+BUS_WIDTH-1:BUS_WIDTH];
        end
      end
    end
  end

  assign bus_out = r_bus_out;
  assign busy    = w_busy;
  assign done    = (r_state == ST_DONE);

endmodule

`default_nettype wire
